// File: rtl/geofence_pkg.sv
// Shared types for the geofence feeder: coordinate width, scene size,
// feeder state encoding and the stored point format.
package geofence_pkg;

  localparam int COORD_W = 10;
  localparam int NPTS    = 7;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } feeder_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/geofence_scene_buf.sv
// Two-bank ping-pong scene store: each bank holds one 7-point scene, is
// filled by the host side and freed by the streaming side via release.
module geofence_scene_buf
  import geofence_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  point_t           wr_pt,
  output logic             wr_ready,
  output logic             wr_last,
  output logic             wr_bank,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output point_t           rd_pt,
  input  logic             rel_en,
  input  logic             rel_bank,
  output logic [1:0]       full
);

  point_t           mem_q [2][NPTS];
  point_t           mem_d [2][NPTS];
  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic [IDX_W-1:0] wcnt_q, wcnt_d;
  logic             wr_fire;

  assign wr_ready = ~full_q[wbank_q];
  assign wr_fire  = wr_en && wr_ready;
  assign wr_last  = wr_fire && (wcnt_q == IDX_W'(NPTS - 1));
  assign wr_bank  = wbank_q;
  assign full     = full_q;
  assign rd_pt    = mem_q[rd_bank][rd_idx];

  // Release and completion never target the same bank in one cycle.
  always_comb begin
    mem_d   = mem_q;
    full_d  = full_q;
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    if (rel_en) begin
      full_d[rel_bank] = 1'b0;
    end
    if (wr_fire) begin
      mem_d[wbank_q][wcnt_q] = wr_pt;
      if (wr_last) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wcnt_d          = '0;
      end else begin
        wcnt_d = wcnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NPTS; i++) begin
          mem_q[b][i] <= '0;
        end
      end
      full_q  <= '0;
      wbank_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      full_q  <= full_d;
      wbank_q <= wbank_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: rtl/geofence_feeder.sv
// Streams buffered 7-point scenes into the geofence checker, owns its reset
// and returns tagged results. Optional WAIT timeout: GEOFENCE_FEEDER_TIMEOUT_EN.
module geofence_feeder
  import geofence_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  output logic               geo_reset,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               valid,
  input  logic               is_inside,
  output logic               res_valid,
  output logic               res_inside,
  output logic [TAG_W-1:0]   res_tag,
  output logic               res_err,
  output logic               spur_err
);

  feeder_state_e    state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [IDX_W-1:0] scnt_q, scnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             geo_reset_q, geo_reset_d;
  point_t           pt_q, pt_d;
  logic             res_valid_q, res_valid_d;
  logic             res_inside_q, res_inside_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             spur_q, spur_d;

  point_t           ld_pt, rd_pt;
  logic             wr_ready, wr_last, wr_bank;
  logic             rd_bank, rel_en, other_full;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       full;

`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             res_err_q, res_err_d;
  assign res_err = res_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign res_err        = 1'b0;
`endif

  assign ld_pt    = '{x: ld_x, y: ld_y};
  assign ld_ready = wr_ready;

  geofence_scene_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (ld_valid),
    .wr_pt    (ld_pt),
    .wr_ready (wr_ready),
    .wr_last  (wr_last),
    .wr_bank  (wr_bank),
    .rd_bank  (rd_bank),
    .rd_idx   (rd_idx),
    .rd_pt    (rd_pt),
    .rel_en   (rel_en),
    .rel_bank (rbank_q),
    .full     (full)
  );

  // A scene finishing loading this very cycle counts as ready for back-to-back.
  assign other_full = full[~rbank_q] || (wr_last && (wr_bank == ~rbank_q));
  assign rd_bank    = (state_q == WAIT) ? ~rbank_q : rbank_q;
  assign rd_idx     = (state_q == SEND) ? scnt_q : '0;

  always_comb begin
    state_d      = state_q;
    rbank_d      = rbank_q;
    scnt_d       = scnt_q;
    tag_d        = tag_q;
    geo_reset_d  = geo_reset_q;
    pt_d         = pt_q;
    res_valid_d  = 1'b0;
    res_inside_d = res_inside_q;
    res_tag_d    = res_tag_q;
    spur_d       = spur_q;
    rel_en       = 1'b0;
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
    tmr_d        = tmr_q;
    res_err_d    = res_err_q;
`endif
    case (state_q)
      IDLE: begin
        geo_reset_d = 1'b1;
        if (valid) spur_d = 1'b1;
        if (full[rbank_q]) begin
          state_d     = SEND;
          geo_reset_d = 1'b0;
          pt_d        = rd_pt;
          scnt_d      = IDX_W'(1);
        end
      end
      SEND: begin
        if (valid) spur_d = 1'b1;
        pt_d = rd_pt;
        if (scnt_q == IDX_W'(NPTS - 1)) begin
          state_d = WAIT;
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end else begin
          scnt_d = scnt_q + IDX_W'(1);
        end
      end
      WAIT: begin
        if (valid) begin
          res_valid_d  = 1'b1;
          res_inside_d = is_inside;
          res_tag_d    = tag_q;
          rel_en       = 1'b1;
          rbank_d      = ~rbank_q;
          tag_d        = tag_q + TAG_W'(1);
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
          res_err_d    = 1'b0;
`endif
          if (other_full) begin
            state_d = SEND;
            pt_d    = rd_pt;
            scnt_d  = IDX_W'(1);
          end else begin
            state_d     = IDLE;
            geo_reset_d = 1'b1;
          end
        end
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
        // Timeout always passes through IDLE so the checker sees a reset pulse.
        else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          res_valid_d  = 1'b1;
          res_inside_d = 1'b0;
          res_err_d    = 1'b1;
          res_tag_d    = tag_q;
          rel_en       = 1'b1;
          rbank_d      = ~rbank_q;
          tag_d        = tag_q + TAG_W'(1);
          state_d      = IDLE;
          geo_reset_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rbank_q      <= 1'b0;
      scnt_q       <= '0;
      tag_q        <= '0;
      geo_reset_q  <= 1'b1;
      pt_q         <= '0;
      res_valid_q  <= 1'b0;
      res_inside_q <= 1'b0;
      res_tag_q    <= '0;
      spur_q       <= 1'b0;
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
      tmr_q        <= '0;
      res_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rbank_q      <= rbank_d;
      scnt_q       <= scnt_d;
      tag_q        <= tag_d;
      geo_reset_q  <= geo_reset_d;
      pt_q         <= pt_d;
      res_valid_q  <= res_valid_d;
      res_inside_q <= res_inside_d;
      res_tag_q    <= res_tag_d;
      spur_q       <= spur_d;
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
      tmr_q        <= tmr_d;
      res_err_q    <= res_err_d;
`endif
    end
  end

  assign geo_reset  = geo_reset_q;
  assign X          = pt_q.x;
  assign Y          = pt_q.y;
  assign res_valid  = res_valid_q;
  assign res_inside = res_inside_q;
  assign res_tag    = res_tag_q;
  assign spur_err   = spur_q;

endmodule

// File: tb/tb_geofence_feeder.sv
// Randomized bench for geofence_feeder: a host loader, a behavioural hexagon
// checker as responder and a scene-queue reference model.
module tb_geofence_feeder;

  localparam int TAG_W = 4;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             ld_valid, ld_ready;
  logic [9:0]       ld_x, ld_y, X, Y;
  logic             geo_reset, valid, is_inside;
  logic             res_valid, res_inside, res_err, spur_err;
  logic [TAG_W-1:0] res_tag;

  always #5 clk = ~clk;

  geofence_feeder #(.TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_x       (ld_x),
    .ld_y       (ld_y),
    .geo_reset  (geo_reset),
    .X          (X),
    .Y          (Y),
    .valid      (valid),
    .is_inside  (is_inside),
    .res_valid  (res_valid),
    .res_inside (res_inside),
    .res_tag    (res_tag),
    .res_err    (res_err),
    .spur_err   (spur_err)
  );

  typedef struct packed {
    logic [6:0][9:0] x;
    logic [6:0][9:0] y;
  } scene_t;

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] pend_q[$];
  scene_t      scene_q[$];
  scene_t      build;
  int          build_cnt, buffered, start_at, idx, cyc, tag_m, exp_tag;
  int          resp_wait, wait_entry;
  bit          active, res_pend, exp_inside, exp_err, spur_m;
  bit          obs_inside, obs_err;
  int          obs_tag;
  logic [9:0]  capx[7];
  logic [9:0]  capy[7];
  int          ld_pct, dly_max, spur_pct;
  bit          resp_en;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Convex polygon test: inside when every edge cross product has one strict sign.
  function automatic bit insideHex(input scene_t s);
    int pos = 0;
    int neg = 0;
    for (int i = 1; i <= 6; i++) begin
      int j = (i == 6) ? 1 : i + 1;
      int c = (int'(s.x[j]) - int'(s.x[i])) * (int'(s.y[0]) - int'(s.y[i]))
            - (int'(s.y[j]) - int'(s.y[i])) * (int'(s.x[0]) - int'(s.x[i]));
      if (c > 0) pos++;
      else if (c < 0) neg++;
    end
    return (pos == 6) || (neg == 6);
  endfunction

  function automatic scene_t makeHex(input int dx, input int dy, input int px, input int py);
    int hx[6] = '{300, 400, 600, 700, 600, 400};
    int hy[6] = '{500, 327, 327, 500, 673, 673};
    scene_t s;
    s.x[0] = 10'(px);
    s.y[0] = 10'(py);
    for (int i = 0; i < 6; i++) begin
      s.x[i+1] = 10'(hx[i] + dx);
      s.y[i+1] = 10'(hy[i] + dy);
    end
    return s;
  endfunction

  function automatic scene_t randScene();
    return makeHex($urandom_range(0, 300), $urandom_range(0, 300),
                   $urandom_range(0, 1023), $urandom_range(0, 1023));
  endfunction

  task automatic queueScene(input scene_t s);
    for (int k = 0; k < 7; k++) pend_q.push_back({s.x[k], s.y[k]});
  endtask

  task automatic modelReset();
    pend_q.delete();
    scene_q.delete();
    build_cnt = 0; buffered = 0; active = 0; start_at = -1; idx = 0;
    tag_m = 0; res_pend = 0; spur_m = 0; resp_wait = 0; wait_entry = 0;
  endtask

  task automatic runCycle(input bit feed);
    bit          real_v, spur_v, lv, ins;
    logic [19:0] pt;
    scene_t      cs;
    @(negedge clk);
    cyc++;
    if (feed && pend_q.size() < 7) queueScene(randScene());
    if (!active && start_at == cyc) begin
      active = 1;
      idx    = 0;
    end
    checkOutput("geo_reset", geo_reset, !active);
    if (active) begin
      int k = (idx > 6) ? 6 : idx;
      checkOutput("X", X, scene_q[0].x[k]);
      checkOutput("Y", Y, scene_q[0].y[k]);
      if (idx < 7) begin
        capx[idx] = X;
        capy[idx] = Y;
      end
      if (idx == 6) wait_entry = cyc;
      idx++;
    end
    checkOutput("ld_ready", ld_ready, buffered < 2);
    checkOutput("res_valid", res_valid, res_pend);
    if (res_pend) begin
      checkOutput("res_inside", res_inside, exp_inside);
      checkOutput("res_tag", res_tag, exp_tag);
      checkOutput("res_err", res_err, exp_err);
      obs_inside = res_inside;
      obs_tag    = res_tag;
      obs_err    = res_err;
      res_pend   = 0;
    end
    checkOutput("spur_err", spur_err, spur_m);

    real_v = 0; spur_v = 0; ins = 0;
    if (active && idx >= 7 && resp_en) begin
      if (resp_wait == 0) begin
        real_v = 1;
        for (int k = 0; k < 7; k++) begin
          cs.x[k] = capx[k];
          cs.y[k] = capy[k];
        end
        ins = insideHex(cs);
      end else begin
        resp_wait--;
      end
    end else if (active && idx >= 2 && idx <= 5 && $urandom_range(0, 99) < spur_pct) begin
      spur_v = 1;
      ins    = 1'($urandom_range(0, 1));
    end
    lv = (pend_q.size() > 0) && ($urandom_range(0, 99) < ld_pct);
    pt = lv ? pend_q[0] : 20'($urandom);

    if (lv && ld_ready) begin
      void'(pend_q.pop_front());
      build.x[build_cnt] = pt[19:10];
      build.y[build_cnt] = pt[9:0];
      build_cnt++;
      if (build_cnt == 7) begin
        scene_q.push_back(build);
        buffered++;
        build_cnt = 0;
        if (!active && buffered == 1) start_at = cyc + 2;
      end
    end
    if (real_v) begin
      res_pend   = 1;
      exp_inside = insideHex(scene_q[0]);
      exp_err    = 0;
      exp_tag    = tag_m;
      tag_m      = (tag_m + 1) % (1 << TAG_W);
      void'(scene_q.pop_front());
      buffered--;
      resp_wait  = $urandom_range(0, dly_max);
      if (buffered > 0) idx = 0;
      else active = 0;
    end
`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
    else if (active && idx >= 7 && cyc == wait_entry + TMO - 1) begin
      res_pend   = 1;
      exp_inside = 0;
      exp_err    = 1;
      exp_tag    = tag_m;
      tag_m      = (tag_m + 1) % (1 << TAG_W);
      void'(scene_q.pop_front());
      buffered--;
      active     = 0;
      if (buffered > 0) start_at = cyc + 2;
    end
`endif
    if (spur_v) spur_m = 1;

    valid     = real_v | spur_v;
    is_inside = ins;
    ld_valid  = lv;
    ld_x      = pt[19:10];
    ld_y      = pt[9:0];
  endtask

  task automatic applyStimulus(input int ncyc, input bit feed);
    repeat (ncyc) runCycle(feed);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend_q.size() != 0 || scene_q.size() != 0 || build_cnt != 0 || res_pend) && n < budget) begin
      runCycle(0);
      n++;
    end
    checkOutput("drain_scenes", scene_q.size() + pend_q.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1; ld_valid = 0; ld_x = 0; ld_y = 0; valid = 0; is_inside = 0;
    cyc = 0;
    modelReset();
    ld_pct = 100; dly_max = 0; spur_pct = 0; resp_en = 1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_geo_reset", geo_reset, 1);
    checkOutput("rst_X", X, 0);
    checkOutput("rst_Y", Y, 0);
    checkOutput("rst_ld_ready", ld_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_inside", res_inside, 0);
    checkOutput("rst_res_tag", res_tag, 0);
    checkOutput("rst_res_err", res_err, 0);
    checkOutput("rst_spur_err", spur_err, 0);
    reset = 0;

    $display("[TB] scene with test point inside the hexagon");
    queueScene(makeHex(0, 0, 500, 500));
    drain(200);
    checkOutput("t1_inside", obs_inside, 1);
    checkOutput("t1_tag", obs_tag, 0);

    $display("[TB] scene with test point outside the hexagon");
    queueScene(makeHex(0, 0, 10, 10));
    drain(200);
    checkOutput("t2_inside", obs_inside, 0);
    checkOutput("t2_tag", obs_tag, 1);

    $display("[TB] two scenes preloaded, back-to-back streaming");
    dly_max = 3; resp_wait = 3;
    queueScene(randScene());
    queueScene(makeHex(0, 0, 500, 500));
    drain(300);
    checkOutput("t3_tag", obs_tag, 3);

    $display("[TB] spurious valid during streaming");
    spur_pct = 60;
    for (int s = 0; s < 3; s++) queueScene(randScene());
    drain(400);
    checkOutput("t4_spur", spur_err, 1);

`ifdef GEOFENCE_FEEDER_TIMEOUT_EN
    $display("[TB] responder silent, timeout path");
    spur_pct = 0; resp_en = 0;
    queueScene(randScene());
    queueScene(randScene());
    drain(300);
    checkOutput("t5_err", obs_err, 1);
    resp_en = 1;
`endif

    $display("[TB] randomized traffic");
    ld_pct = 60; spur_pct = 5;
    applyStimulus(1200, 1);
    drain(400);

    $display("[TB] reset in the middle of streaming");
    ld_pct = 100; spur_pct = 0;
    queueScene(randScene());
    n = 0;
    while (!(active && idx == 3) && n < 200) begin
      runCycle(0);
      n++;
    end
    checkOutput("t6_reached_send", active && idx == 3, 1);
    reset = 1; ld_valid = 0; valid = 0;
    #1;
    checkOutput("t6_geo_reset", geo_reset, 1);
    checkOutput("t6_X", X, 0);
    checkOutput("t6_Y", Y, 0);
    checkOutput("t6_ld_ready", ld_ready, 1);
    checkOutput("t6_spur", spur_err, 0);
    modelReset();
    @(negedge clk);
    reset = 0;
    queueScene(makeHex(0, 0, 500, 500));
    drain(200);
    checkOutput("t6_tag", obs_tag, 0);

    ld_pct = 70; spur_pct = 3;
    applyStimulus(1000, 1);
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
